// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache miss unit.
package dcache_pkg;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_BITS  = 3;
  localparam int Y_BITS     = 3;
  localparam int LINE_OFF   = BEAT_BITS + Y_BITS;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;
  localparam logic [2:0] SZ_D = 3'b011;

  // slot: 0 = miss channel 1, 1 = miss channel 2
  typedef struct packed {
    logic        write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] data;
    logic        slot;
  } miss_req_t;

  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return a & ~((64'd1 << LINE_OFF) - 64'd1);
  endfunction
endpackage

// File: rtl/dcache_miss_unit_if.sv
// Memory-side (AXI bridge) request/response bundle of the miss unit.
interface dcache_miss_unit_if;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [63:0] rd_req_addr;
  logic        rd_data_valid;
  logic [63:0] rd_data;
  logic        rd_data_last;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [63:0] wr_req_addr;
  logic [2:0]  wr_req_size;
  logic [63:0] wr_req_data;
  logic        wr_resp_valid;

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_size, wr_req_data,
    input  rd_req_ready, rd_data_valid, rd_data, rd_data_last, wr_req_ready, wr_resp_valid
  );
  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_size, wr_req_data,
    output rd_req_ready, rd_data_valid, rd_data, rd_data_last, wr_req_ready, wr_resp_valid
  );
endinterface

// File: rtl/dcache_miss_unit_arbiter.sv
// Fixed-priority pick between the two miss slots plus same-line read merge detect.
module miss_arbiter import dcache_pkg::*; (
  input  miss_req_t req1,
  input  miss_req_t req2,
  input  logic      valid1,
  input  logic      valid2,
  input  logic      mask1,
  input  logic      mask2,
  output logic      cap_en,
  output miss_req_t cap_req,
  output logic      cap_merge
);
  logic v1, v2;

  // mask hides a slot whose done pulse is on the wire this cycle
  always_comb begin
    v1        = valid1 & ~mask1;
    v2        = valid2 & ~mask2;
    cap_en    = v1 | v2;
    cap_req   = v1 ? req1 : req2;
    cap_merge = v1 & v2 & ~req1.write & ~req2.write &
                (line_addr(req1.addr) == line_addr(req2.addr));
  end
endmodule

// File: rtl/dcache_miss_unit.sv
// Data-cache miss unit: line refill bursts for read misses, single stores for write misses.
module dcache_miss_unit import dcache_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss1_valid,
  input  logic                 miss1_write,
  input  logic [2:0]           miss1_size,
  input  logic [63:0]          miss1_addr,
  input  logic [63:0]          miss1_data,
  input  logic                 miss2_valid,
  input  logic                 miss2_write,
  input  logic [2:0]           miss2_size,
  input  logic [63:0]          miss2_addr,
  input  logic [63:0]          miss2_data,
  output logic                 miss1_done,
  output logic                 miss2_done,
  output logic                 fill_valid,
  output logic [63:0]          fill_addr,
  output logic [BEAT_BITS-1:0] fill_beat,
  output logic [63:0]          fill_data,
  output logic                 fill_last,
  output logic                 busy,
  output logic                 proto_err,
  dcache_miss_unit_if.master   mem
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]           state_q, state_d;
  miss_req_t            req_q, req_d;
  logic                 merge_q, merge_d;
  logic [BEAT_BITS-1:0] cnt_q, cnt_d;
  logic                 perr_q, perr_d;

  miss_req_t req1, req2, cap_req;
  logic      cap_en, cap_merge, mask1, mask2, beat_last;

  always_comb begin
    req1      = '{miss1_write, miss1_size, miss1_addr, miss1_data, 1'b0};
    req2      = '{miss2_write, miss2_size, miss2_addr, miss2_data, 1'b1};
    mask1     = (state_q == S_DONE) && (!req_q.slot || merge_q);
    mask2     = (state_q == S_DONE) && ( req_q.slot || merge_q);
    beat_last = (cnt_q == BEAT_BITS'(LINE_BEATS - 1));
  end

  miss_arbiter u_arb (
    .req1(req1), .req2(req2), .valid1(miss1_valid), .valid2(miss2_valid),
    .mask1(mask1), .mask2(mask2),
    .cap_en(cap_en), .cap_req(cap_req), .cap_merge(cap_merge)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    merge_d = merge_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    case (state_q)
      // DONE re-arbitrates so a waiting slot starts without an idle bubble
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cap_en) begin
          req_d   = cap_req;
          merge_d = cap_merge;
          state_d = cap_req.write ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_RD_REQ: if (mem.rd_req_ready) begin
        state_d = S_RD_DATA;
        cnt_d   = '0;
      end
      // the beat counter alone ends the burst; rd_data_last is only audited
      S_RD_DATA: if (mem.rd_data_valid) begin
        cnt_d = cnt_q + BEAT_BITS'(1);
        if (mem.rd_data_last != beat_last) perr_d = 1'b1;
        if (beat_last) state_d = S_DONE;
      end
      S_WR_REQ:  if (mem.wr_req_ready)  state_d = S_WR_RESP;
      S_WR_RESP: if (mem.wr_resp_valid) state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      merge_q <= 1'b0;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      merge_q <= merge_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    mem.rd_req_valid = (state_q == S_RD_REQ);
    mem.rd_req_addr  = line_addr(req_q.addr);
    fill_valid       = (state_q == S_RD_DATA) && mem.rd_data_valid;
    fill_addr        = line_addr(req_q.addr);
    fill_beat        = cnt_q;
    fill_data        = fill_valid ? mem.rd_data : '0;
    fill_last        = fill_valid && beat_last;
    mem.wr_req_valid = (state_q == S_WR_REQ);
    mem.wr_req_addr  = req_q.addr;
    mem.wr_req_size  = req_q.size;
    mem.wr_req_data  = req_q.data;
    miss1_done       = mask1;
    miss2_done       = mask2;
    proto_err        = perr_q;
  end
endmodule

// File: doc/dcache_miss_unit.md
Name: dcache_miss_unit

Overview:
Services the two MEM-stage data-cache miss channels (superscalar slots 1 and 2).
- Read misses: fetches the whole cache line as a B-beat burst from the memory interface and streams it back to the cache as fill beats.
- Write misses (write-no-allocate): forwards one sized store to memory.
- Sits between the data cache and the AXI bridge; completion pulses let the cache clear its miss/stall state.

Parameters:
B, 8, beats (64-bit words) per line
b, 3, log2(B), beat index bits
y, 3, byte-offset bits within a word

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
miss1_valid  in  1  slot-1 miss pending; level, held until miss1_done
miss1_write  in  1  1 = store miss, 0 = read miss
miss1_size  in  3  store size code (000 sb, 001 sh, 010 sw, 011 sd)
miss1_addr  in  64  byte address
miss1_data  in  64  store data, right-aligned
miss2_valid, miss2_write, miss2_size, miss2_addr, miss2_data  in  1/1/3/64/64  same for slot 2
miss1_done  out  1  one-cycle pulse: slot-1 request finished
miss2_done  out  1  one-cycle pulse: slot-2 request finished
fill_valid  out  1  fill beat valid this cycle
fill_addr  out  64  line-aligned address of the line being filled
fill_beat  out  b  word index within the line
fill_data  out  64  beat data
fill_last  out  1  final beat of the line
rd_req_valid  out  1  burst read request
rd_req_ready  in  1  memory accepts rd request
rd_req_addr  out  64  line-aligned burst address
rd_data_valid  in  1  read beat valid
rd_data  in  64  read beat
rd_data_last  in  1  memory's last-beat marker
wr_req_valid  out  1  single store request
wr_req_ready  in  1  memory accepts store
wr_req_addr  out  64  byte address
wr_req_size  out  3  size code
wr_req_data  out  64  store data
wr_resp_valid  in  1  store acknowledged
busy  out  1  FSM not in IDLE
proto_err  out  1  sticky: rd_data_last disagreed with beat counter

Behaviour:
Reset values:
- All outputs 0; FSM goes to IDLE.
- Beat counter, captured-request registers and proto_err all cleared.
- Reset mid-burst or mid-store abandons the transaction: no done pulse, and valids drop the cycle after reset is sampled.

Arbitration (in IDLE, or in DONE when the slot just finished still holds a request):
- Slot 1 has priority (program order). Slot 2 is served only when slot 1 is not valid or has just completed.
- The winning request (write, size, addr, data, slot id) is captured into registers. Inputs are not used after capture.

States:
- IDLE -> RD_REQ (read winner) or WR_REQ (write winner).
- RD_REQ: rd_req_valid=1, rd_req_addr = {addr[63:b+y], 0}. On rd_req_ready, go to RD_DATA and set the counter to 0.
- RD_DATA: each rd_data_valid gives fill_valid=1 combinationally in the same cycle.
  - fill_beat = counter, fill_data = rd_data, fill_addr = captured line address.
  - Counter increments per beat. fill_last=1 when counter == B-1, then go to DONE.
  - If rd_data_last != (counter == B-1), set proto_err. The counter alone decides the end of the burst; beats after the counted last are ignored.
- WR_REQ: wr_req_* driven from the captured request. On wr_req_ready, go to WR_RESP.
- WR_RESP: on wr_resp_valid, go to DONE.
- DONE: one cycle. Pulse done for the captured slot, then go to IDLE.

Line merge:
- Read miss in service and the other slot holds a read miss to the same line (addr[63:b+y] equal): one refill satisfies both.
- In DONE both miss1_done and miss2_done pulse in the same cycle.

Other rules:
- Store address equal to a line being refilled is not merged; it is served in a following transaction.
- Latency: a read miss with zero-wait memory takes 1 (IDLE) + 1 (RD_REQ) + B (beats) + 1 (DONE) cycles. A store takes 4 cycles.
- A done pulse is never issued for a slot whose valid is low at capture time.

Decomposition:
- Shared package dcache_pkg:
  - size-code localparams SZ_B/SZ_H/SZ_W/SZ_D;
  - line_addr function (clear low b+y bits);
  - miss_req_t struct {write, size, addr, data, slot}.
- One natural sub-module, miss_arbiter: fixed-priority select, same-line merge detect, capture enable.

Test Plan:
- Slot-1 read miss addr 0x1048, memory returns data 0x100..0x107 with zero waits -> rd_req_addr 0x1040; fill_beat 0..7 with matching data; fill_last on beat 7; miss1_done pulses at cycle 11.
- Slot-1 sd miss addr 0x2000, data 0xDEADBEEF, size 011, wr_req_ready delayed 3 cycles -> wr_req_* stable until ready; miss1_done one cycle after wr_resp_valid.
- Both slots read-miss, lines 0x3000 and 0x3018 (same line) -> single burst; miss1_done and miss2_done both pulse in the same cycle.
- Slot 1 reads 0x4000 and slot 2 writes 0x5000 simultaneously -> burst completes first, miss1_done pulses, then the store is issued and miss2_done follows.
- reset asserted after beat 3 of a burst -> all valids and done pulses 0 next cycle; busy=0; no miss1_done.
- rd_data_last asserted on beat 5 -> proto_err=1 and stays set; fill_last still on beat 7.
